// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - word-addressed 32-bit instruction store with combinational read
// and a synchronous program-load port.
module inst_rom #(
  parameter int    DEPTH     = 64,
  parameter int    ADDR_BITS = 6,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  output logic [31:0] inst,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  typedef logic [31:0] mem_t [DEPTH];

  // Power-up image: the built-in demo program unless an external image is selected.
  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = 32'h0000_0000;
    if (INIT_FILE == "") begin
      img[0] = 32'h0C20_0005;
      img[1] = 32'h0C40_0003;
      if (DEPTH > 2) img[2] = 32'h2461_1000;
      if (DEPTH > 3) img[3] = 32'h0860_0000;
    end
    return img;
  endfunction

  mem_t mem = init_image();

  logic rd_in_range;
  logic wr_in_range;

  // Any set bit above the index field means out of range; no aliasing.
  assign rd_in_range = (address   >> ADDR_BITS) == 32'h0;
  assign wr_in_range = (load_addr >> ADDR_BITS) == 32'h0;

  always_ff @(posedge clk) begin
    if (rst && load_en && wr_in_range) begin
      mem[load_addr[ADDR_BITS-1:0]] <= load_data;
    end
  end

  always_comb begin
    inst = 32'h0000_0000;
    if (rst && rd_in_range) begin
      inst = mem[address[ADDR_BITS-1:0]];
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// tb/tb_inst_rom.sv - directed and randomized checks of inst_rom against a
// behavioural memory model.
module tb_inst_rom;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] inst;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  inst_rom #(.DEPTH(DEPTH), .ADDR_BITS(6), .INIT_FILE("")) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .inst      (inst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
    if (!r || a >= 32'(DEPTH)) return 32'h0;
    return model[a[5:0]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_edge();
    if (rst && load_en && load_addr < 32'(DEPTH)) model[load_addr[5:0]] = load_data;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    model[0] = 32'h0C20_0005;
    model[1] = 32'h0C40_0003;
    model[2] = 32'h2461_1000;
    model[3] = 32'h0860_0000;

    rst = 1'b0; address = 32'd1; load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
    #1 check("reset_forces_zero", inst, 32'h0);

    @(negedge clk) rst = 1'b1;
    for (int a = 0; a < 5; a++) begin
      address = 32'(a);
      #1 check($sformatf("default_%0d", a), inst, model_read(1'b1, 32'(a)));
    end
    address = 32'd64;         #1 check("oor_depth", inst, 32'h0);
    address = 32'hFFFF_FFFF;  #1 check("oor_max", inst, 32'h0);
    address = 32'd63;         #1 check("last_word", inst, 32'h0);

    address = 32'd2;
    @(posedge clk); #2 rst = 1'b0;
    #1 check("async_reset_low", inst, 32'h0);
    rst = 1'b1;
    #1 check("async_reset_release", inst, 32'h2461_1000);

    @(negedge clk);
    load_en = 1'b1; load_addr = 32'd5; load_data = 32'h2483_2000; address = 32'd5;
    #1 check("load_before_edge", inst, 32'h0);
    @(posedge clk); model_edge(); #1 check("load_after_edge", inst, 32'h2483_2000);

    @(negedge clk);
    rst = 1'b0; load_addr = 32'd6; load_data = 32'h1111_1111; address = 32'd6;
    @(posedge clk); model_edge();
    @(negedge clk); rst = 1'b1; load_en = 1'b0;
    #1 check("load_ignored_in_reset", inst, 32'h0);

    @(negedge clk);
    load_en = 1'b1; load_addr = 32'd100; load_data = 32'h2222_2222;
    @(posedge clk); model_edge();
    @(negedge clk); load_en = 1'b0;
    address = 32'd100; #1 check("oor_load_read", inst, 32'h0);
    address = 32'd36;  #1 check("oor_load_no_alias", inst, 32'h0);

    address = 32'd5;
    rst = 1'b0; #2 rst = 1'b1;
    #1 check("load_survives_reset", inst, 32'h2483_2000);

    @(negedge clk);
    load_en = 1'b1; load_addr = 32'd1; load_data = 32'hDEAD_BEEF; address = 32'd1;
    #1 check("rdw_old", inst, 32'h0C40_0003);
    @(posedge clk); model_edge(); #1 check("rdw_new", inst, 32'hDEAD_BEEF);

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 9) != 0);
      load_en   = $urandom_range(0, 1) == 1;
      load_addr = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 90));
      load_data = $urandom();
      address   = ($urandom_range(0, 3) == 0) ? load_addr : 32'($urandom_range(0, 80));
      #1 check("rand_pre", inst, model_read(rst, address));
      @(posedge clk); model_edge();
      #1 check("rand_post", inst, model_read(rst, address));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
